phy_rx_data_fsm: RTL and testbench

PHY_RX_DATA_FSM -- requirements
Module: phy_rx_data_fsm

---
 rtl/phy_rx_data_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_phy_rx_data_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_data_fsm.sv
// phy_rx_data_fsm
// Receive-side data buffer and hand-off FSM between the PHY receiver and
// the data-link layer. Words from the receiver are queued in a small FIFO.
// The head word is offered to the DL one at a time. After each accepted word
// the FSM waits for the DL to report the next Top-FSM state, or times out.
module phy_rx_data_fsm #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int STATE_W     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  input  logic                    i_ns_valid,
  input  logic [STATE_W-1:0]      i_next_state,
  output logic [STATE_W-1:0]      o_next_state,
  output logic                    o_ns_valid,
  output logic                    o_timeout,
  output logic                    o_overflow,
  input  logic                    i_clr,
  output logic [$clog2(DEPTH):0]  o_count
);

  // Pointer, occupancy and timeout-counter widths.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  // Hand-off FSM encoding.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GIVE_DATA = 2'd1;
  localparam logic [1:0] ST_WAIT_NS   = 2'd2;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TMR_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] TMR_ONE  = {{(TW-1){1'b0}}, 1'b1};
  // Last counter value seen in WAIT_NS before the timeout fires.
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

  // Storage and state.
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      count_nxt_s;
  logic               data_ready_r;
  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [TW-1:0]      timer_r;
  logic               valid_r;
  logic               ns_valid_r;
  logic               timeout_r;
  logic               overflow_r;
  logic [STATE_W-1:0] next_state_r;

  // Handshake qualifiers.
  logic push_s;
  logic pop_s;
  logic drop_s;
  logic ns_take_s;
  logic tmo_hit_s;

  // Port drive: everything except o_data comes straight from a flop. o_data
  // is the addressed head entry, which only moves on a clock edge.
  assign o_data_ready = data_ready_r;
  assign o_data       = mem_r[rd_ptr_r];
  assign o_valid      = valid_r;
  assign o_next_state = next_state_r;
  assign o_ns_valid   = ns_valid_r;
  assign o_timeout    = timeout_r;
  assign o_overflow   = overflow_r;
  assign o_count      = count_r;

  // Push/pop/drop qualification. Ready comes from a register, so a pop in
  // this cycle never opens the FIFO to a push in the same cycle.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    drop_s = 1'b0;
    if (i_data_valid) begin
      push_s = data_ready_r;
      drop_s = ~data_ready_r;
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
    if (valid_r) begin
      pop_s = i_ready;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Occupancy after the coming edge; simultaneous push and pop cancel.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Next-state logic. In WAIT_NS a DL report beats a coincident timeout.
  always_comb begin
    state_nxt_s = state_r;
    ns_take_s   = 1'b0;
    tmo_hit_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          state_nxt_s = ST_GIVE_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GIVE_DATA: begin
        if (pop_s) begin
          state_nxt_s = ST_WAIT_NS;
        end else begin
          state_nxt_s = ST_GIVE_DATA;
        end
      end
      ST_WAIT_NS: begin
        if (i_ns_valid) begin
          ns_take_s = 1'b1;
          if (count_nxt_s != CNT_ZERO) begin
            state_nxt_s = ST_GIVE_DATA;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (timer_r == TMR_LAST) begin
          tmo_hit_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_NS;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FIFO storage write. Contents are don't-care until pointed at by a valid
  // read, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointers, occupancy and registered ready; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      data_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r      <= count_nxt_s;
      data_ready_r <= (count_nxt_s != CNT_FULL);
    end
  end

  // FSM state, WAIT_NS cycle counter and registered o_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      timer_r <= TMR_ZERO;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s == ST_GIVE_DATA);
      if ((state_r == ST_WAIT_NS) && (state_nxt_s == ST_WAIT_NS)) begin
        timer_r <= timer_r + TMR_ONE;
      end else begin
        timer_r <= TMR_ZERO;
      end
    end
  end

  // Next-state capture, one-cycle pulses and the sticky overflow flag.
  // A drop in the same cycle as a clear keeps the flag set so no loss is hidden.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      next_state_r <= {STATE_W{1'b0}};
      ns_valid_r   <= 1'b0;
      timeout_r    <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      ns_valid_r <= ns_take_s;
      timeout_r  <= tmo_hit_s;
      if (ns_take_s) begin
        next_state_r <= i_next_state;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (i_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_data_fsm.sv
// Self-checking bench for phy_rx_data_fsm (DATA_W=8, DEPTH=4, TIMEOUT_CYC=8).
module tb_phy_rx_data_fsm;

  logic       clk;
  logic       rst;
  logic [7:0] i_data;
  logic       i_data_valid;
  logic       o_data_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       i_ns_valid;
  logic [1:0] i_next_state;
  logic [1:0] o_next_state;
  logic       o_ns_valid;
  logic       o_timeout;
  logic       o_overflow;
  logic       i_clr;
  logic [2:0] o_count;

  int checks = 0;
  int errors = 0;

  phy_rx_data_fsm #(
    .DATA_W(8), .DEPTH(4), .STATE_W(2), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .i_ns_valid(i_ns_valid), .i_next_state(i_next_state),
    .o_next_state(o_next_state), .o_ns_valid(o_ns_valid), .o_timeout(o_timeout),
    .o_overflow(o_overflow), .i_clr(i_clr), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic       rdy;
    logic       nsv;
    logic [1:0] ns;
    logic       clr;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_nsv;
    logic [1:0] e_ns;
    logic       e_tmo;
    logic       e_ovf;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic rdy,
                       input logic nsv, input logic [1:0] ns, input logic clr);
    i_data_valid = dv;
    i_data       = d;
    i_ready      = rdy;
    i_ns_valid   = nsv;
    i_next_state = ns;
    i_clr        = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           dv    d      rdy   nsv   ns     clr   ready valid data   nsv   ns     tmo   ovf   cnt
    // single word hand-off
    vec[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1};
    vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 2'b00, 1'b0, 1'b0, 3'd1};
    vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0};
    vec[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0, 3'd0};
    vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0};
    // fill and overflow with the DL stalled
    vec[5]  = '{1'b1, 8'h01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'b10, 1'b0, 1'b0, 3'd1};
    vec[6]  = '{1'b1, 8'h02, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 2'b10, 1'b0, 1'b0, 3'd2};
    vec[7]  = '{1'b1, 8'h03, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 2'b10, 1'b0, 1'b0, 3'd3};
    vec[8]  = '{1'b1, 8'h04, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 2'b10, 1'b0, 1'b0, 3'd4};
    vec[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 2'b10, 1'b0, 1'b1, 3'd4};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 2'b10, 1'b0, 1'b0, 3'd4};

    // Reset state
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    step();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_data_ready, 1'b1);
    chk("rst_count", o_count, 3'd0);
    chk("rst_ns", o_next_state, 2'b00);
    chk("rst_nsv", o_ns_valid, 1'b0);
    chk("rst_tmo", o_timeout, 1'b0);
    chk("rst_ovf", o_overflow, 1'b0);
    rst = 1'b1;
    step();
    chk("post_rst_valid", o_valid, 1'b0);

    // Table-driven single word and fill/overflow
    for (int i = 0; i < 11; i++) begin
      drive(vec[i].dv, vec[i].d, vec[i].rdy, vec[i].nsv, vec[i].ns, vec[i].clr);
      step();
      chk($sformatf("v%0d_ready", i), o_data_ready, vec[i].e_ready);
      chk($sformatf("v%0d_valid", i), o_valid, vec[i].e_valid);
      if (vec[i].e_valid) chk($sformatf("v%0d_data", i), o_data, vec[i].e_data);
      chk($sformatf("v%0d_nsv", i), o_ns_valid, vec[i].e_nsv);
      chk($sformatf("v%0d_ns", i), o_next_state, vec[i].e_ns);
      chk($sformatf("v%0d_tmo", i), o_timeout, vec[i].e_tmo);
      chk($sformatf("v%0d_ovf", i), o_overflow, vec[i].e_ovf);
      chk($sformatf("v%0d_cnt", i), o_count, vec[i].e_cnt);
    end

    // Back-pressure: head word and occupancy stay put
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_valid", o_valid, 1'b1);
      chk("bp_data", o_data, 8'h01);
      chk("bp_count", o_count, 3'd4);
    end

    // Timeout: pop 0x01, then no DL report
    drive(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
    step();
    chk("to_entry_valid", o_valid, 1'b0);
    chk("to_entry_cnt", o_count, 3'd3);
    chk("to_entry_ready", o_data_ready, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("to_c%0d_tmo", k), o_timeout, (k == 8) ? 1'b1 : 1'b0);
      chk($sformatf("to_c%0d_valid", k), o_valid, 1'b0);
    end
    chk("to_ns_kept", o_next_state, 2'b10);
    chk("to_nsv", o_ns_valid, 1'b0);
    step();
    chk("to_pulse_end", o_timeout, 1'b0);
    chk("to_regive_valid", o_valid, 1'b1);
    chk("to_regive_data", o_data, 8'h02);

    // Race: DL report on the final timeout cycle wins
    drive(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
    step();
    chk("race_entry_valid", o_valid, 1'b0);
    chk("race_entry_cnt", o_count, 3'd2);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) drive(1'b0, 8'h00, 1'b0, 1'b1, 2'b01, 1'b0);
      step();
      if (k < 8) chk($sformatf("race_c%0d_tmo", k), o_timeout, 1'b0);
    end
    chk("race_nsv", o_ns_valid, 1'b1);
    chk("race_tmo", o_timeout, 1'b0);
    chk("race_ns", o_next_state, 2'b01);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    chk("race_nsv_end", o_ns_valid, 1'b0);
    chk("race_give_valid", o_valid, 1'b1);
    chk("race_give_data", o_data, 8'h03);

    // Reset mid-operation: 3 words buffered while in WAIT_NS
    drive(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
    step();
    chk("mr_pop_cnt", o_count, 3'd1);
    drive(1'b1, 8'h06, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    drive(1'b1, 8'h07, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    chk("mr_buf_cnt", o_count, 3'd3);
    chk("mr_wait_valid", o_valid, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_valid", o_valid, 1'b0);
    chk("mr_ready", o_data_ready, 1'b1);
    chk("mr_count", o_count, 3'd0);
    chk("mr_ns", o_next_state, 2'b00);
    chk("mr_nsv", o_ns_valid, 1'b0);
    chk("mr_tmo", o_timeout, 1'b0);
    chk("mr_ovf", o_overflow, 1'b0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mr_after_valid", o_valid, 1'b0);
      chk("mr_after_nsv", o_ns_valid, 1'b0);
      chk("mr_after_cnt", o_count, 3'd0);
    end

    // Fresh push after reset: o_valid two edges later
    drive(1'b1, 8'h5A, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    chk("np_lat1_valid", o_valid, 1'b0);
    chk("np_lat1_cnt", o_count, 3'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
    chk("np_lat2_valid", o_valid, 1'b1);
    chk("np_lat2_data", o_data, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
